// File: rtl/rv_dmem_ctrl_if.sv
// Pipeline-side request and word-wide memory bus seen by the data-memory controller.
// slave = the controller, master = the pipeline/memory environment driving it.
interface rv_dmem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_dc_req_valid;
  logic            i_dc_req_wen;
  logic [2:0]      i_dc_req_func3;
  logic [XLEN-1:0] i_dc_req_addr;
  logic [XLEN-1:0] i_dc_req_wdata;
  logic            o_dc_stall;
  logic [XLEN-1:0] o_dc_rdata;
  logic            o_dc_rdata_valid;
  logic            o_dc_fault;
  logic            o_dc_bus_req;
  logic            o_dc_bus_we;
  logic [XLEN-1:0] o_dc_bus_addr;
  logic [3:0]      o_dc_bus_be;
  logic [XLEN-1:0] o_dc_bus_wdata;
  logic            i_dc_bus_gnt;
  logic            i_dc_bus_rvalid;
  logic [XLEN-1:0] i_dc_bus_rdata;
  logic            i_dc_bus_err;

  modport slave (
    input  i_dc_req_valid, i_dc_req_wen, i_dc_req_func3, i_dc_req_addr, i_dc_req_wdata,
    input  i_dc_bus_gnt, i_dc_bus_rvalid, i_dc_bus_rdata, i_dc_bus_err,
    output o_dc_stall, o_dc_rdata, o_dc_rdata_valid, o_dc_fault,
    output o_dc_bus_req, o_dc_bus_we, o_dc_bus_addr, o_dc_bus_be, o_dc_bus_wdata
  );

  modport master (
    output i_dc_req_valid, i_dc_req_wen, i_dc_req_func3, i_dc_req_addr, i_dc_req_wdata,
    output i_dc_bus_gnt, i_dc_bus_rvalid, i_dc_bus_rdata, i_dc_bus_err,
    input  o_dc_stall, o_dc_rdata, o_dc_rdata_valid, o_dc_fault,
    input  o_dc_bus_req, o_dc_bus_we, o_dc_bus_addr, o_dc_bus_be, o_dc_bus_wdata
  );
endinterface

// File: rtl/rv_dmem_ctrl.sv
// Data-memory controller: turns MEM-stage loads/stores into req/gnt/rvalid bus accesses.
//   state  | meaning
//   IDLE   | waiting for a request; illegal/misaligned ones fault here without bus access
//   REQ    | bus_req held with registered address/be/data until gnt
//   RDWAIT | load granted, waiting for rvalid
//   DONE   | access finished, stall released, result/fault visible for one cycle
module rv_dmem_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_dc_clk,
  input  logic              i_dc_rstn,
  rv_dmem_ctrl_if.slave     dc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDWAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q;
  logic            bus_req_q, bus_we_q;
  logic [XLEN-1:0] bus_addr_q, bus_wdata_q;
  logic [3:0]      bus_be_q;
  logic [2:0]      func3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] rdata_q;
  logic            rdata_valid_q, fault_q;

  logic            illegal, misaligned, bad_req, accept, timeout;
  logic [1:0]      lane;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc, load_ext;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    lane       = dc.i_dc_req_addr[1:0];
    illegal    = (dc.i_dc_req_func3 == 3'b011) || (dc.i_dc_req_func3 == 3'b110) ||
                 (dc.i_dc_req_func3 == 3'b111) || (dc.i_dc_req_wen && dc.i_dc_req_func3[2]);
    misaligned = ((dc.i_dc_req_func3[1:0] == 2'b01) && lane[0]) ||
                 ((dc.i_dc_req_func3 == 3'b010) && (lane != 2'b00));
    bad_req    = illegal || misaligned;
    accept     = (state_q == S_IDLE) && dc.i_dc_req_valid && !bad_req;
    timeout    = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    case (dc.i_dc_req_func3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << lane;
        wdata_calc = {4{dc.i_dc_req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << lane;
        wdata_calc = {2{dc.i_dc_req_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = dc.i_dc_req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = dc.i_dc_bus_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dc.i_dc_bus_rdata[31:16] : dc.i_dc_bus_rdata[15:0];
    case (func3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = dc.i_dc_bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_REQ;
      S_REQ: begin
        if (dc.i_dc_bus_gnt) state_d = (bus_we_q || dc.i_dc_bus_err) ? S_DONE : S_RDWAIT;
        else if (timeout)    state_d = S_DONE;
      end
      S_RDWAIT: if (dc.i_dc_bus_rvalid || timeout) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_dc_clk or negedge i_dc_rstn) begin
    if (!i_dc_rstn) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_dc_clk or negedge i_dc_rstn) begin
    if (!i_dc_rstn) begin
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      func3_q       <= '0;
      lane_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q       <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= dc.i_dc_req_wen;
            bus_addr_q  <= {dc.i_dc_req_addr[XLEN-1:2], 2'b00};
            bus_be_q    <= be_calc;
            bus_wdata_q <= wdata_calc;
            func3_q     <= dc.i_dc_req_func3;
            lane_q      <= lane;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (dc.i_dc_bus_gnt || timeout) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            // any bus fault, store or load, clears the load result register
            if (!dc.i_dc_bus_gnt || dc.i_dc_bus_err) begin
              fault_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        S_RDWAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (dc.i_dc_bus_rvalid && !dc.i_dc_bus_err) begin
            rdata_q       <= load_ext;
            rdata_valid_q <= 1'b1;
          end else if (dc.i_dc_bus_rvalid || timeout) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // stall and IDLE-time fault are combinational, so they are gated by reset as well
  assign dc.o_dc_stall       = i_dc_rstn && (accept || (state_q == S_REQ) || (state_q == S_RDWAIT));
  assign dc.o_dc_fault       = i_dc_rstn && (fault_q ||
                               ((state_q == S_IDLE) && dc.i_dc_req_valid && bad_req));
  assign dc.o_dc_rdata       = rdata_q;
  assign dc.o_dc_rdata_valid = rdata_valid_q;
  assign dc.o_dc_bus_req     = bus_req_q;
  assign dc.o_dc_bus_we      = bus_we_q;
  assign dc.o_dc_bus_addr    = bus_addr_q;
  assign dc.o_dc_bus_be      = bus_be_q;
  assign dc.o_dc_bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Bench for rv_dmem_ctrl: directed scenarios plus randomized accesses against a
// transaction-level model (stall length, bus fields, fault/valid pulses, load result).
module tb_rv_dmem_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_dmem_ctrl_if #(.XLEN(32)) dc ();

  rv_dmem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_dc_clk (clk),
    .i_dc_rstn(rst_n),
    .dc       (dc)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic drive_idle();
    dc.i_dc_req_valid  = 1'b0;
    dc.i_dc_req_wen    = 1'b0;
    dc.i_dc_req_func3  = 3'b000;
    dc.i_dc_req_addr   = '0;
    dc.i_dc_req_wdata  = '0;
    dc.i_dc_bus_gnt    = 1'b0;
    dc.i_dc_bus_rvalid = 1'b0;
    dc.i_dc_bus_rdata  = '0;
    dc.i_dc_bus_err    = 1'b0;
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] f3, input int lane, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the access has left DONE (or faulted in IDLE).
  // g = REQ cycles before gnt, r = RDWAIT cycles before rvalid.
  task automatic do_access(input string name, input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int g, input int r, input logic err, input logic [31:0] rword);
    bit illegal, misal, legal, tout, done, granted, rv_given;
    int lane, need, exp_stall, exp_req, exp_fault, exp_rv;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr;
    int cyc, stall_n, fault_n, rv_n, req_n, bad_bus, idle_bus, rd_wait;

    lane    = int'(addr % 4);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wen && f3[2]);
    misal   = ((f3 == 3'b001 || f3 == 3'b101) && (lane % 2 == 1)) || (f3 == 3'b010 && lane != 0);
    legal   = !illegal && !misal;
    case (f3 % 4)
      0:       begin exp_be = 4'(1 << lane); exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
      1:       begin exp_be = 4'(3 << lane); exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      default: begin exp_be = 4'hF;          exp_wd = wd; end
    endcase
    exp_addr  = addr - 32'(lane);
    need      = wen ? g + 1 : g + r + 2;
    tout      = legal && (need > TO);
    exp_stall = !legal ? 0 : (tout ? 1 + TO : 1 + need);
    exp_req   = !legal ? 0 : ((g + 1 < TO) ? g + 1 : TO);
    exp_fault = (!legal || tout || err) ? 1 : 0;
    exp_rv    = (legal && !wen && !tout && !err) ? 1 : 0;
    if (exp_rv == 1)           model_rdata = load_value(f3, lane, rword);
    else if (legal && exp_fault == 1) model_rdata = '0;

    dc.i_dc_req_valid = 1'b1;
    dc.i_dc_req_wen   = wen;
    dc.i_dc_req_func3 = f3;
    dc.i_dc_req_addr  = addr;
    dc.i_dc_req_wdata = wd;
    cyc = 0; stall_n = 0; fault_n = 0; rv_n = 0; req_n = 0; bad_bus = 0; idle_bus = 0;
    rd_wait = 0; done = 0; granted = 0; rv_given = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (dc.o_dc_stall) stall_n++;
      if (dc.o_dc_fault) fault_n++;
      if (dc.o_dc_rdata_valid) rv_n++;
      if (dc.o_dc_bus_req) begin
        req_n++;
        if (dc.o_dc_bus_addr !== exp_addr || dc.o_dc_bus_be !== exp_be ||
            dc.o_dc_bus_wdata !== exp_wd || dc.o_dc_bus_we !== wen) bad_bus++;
      end else if (dc.o_dc_bus_we || dc.o_dc_bus_be != 0 || dc.o_dc_bus_addr != 0 ||
                   dc.o_dc_bus_wdata != 0) idle_bus++;
      done = !dc.o_dc_stall;
      dc.i_dc_bus_gnt    = 1'b0;
      dc.i_dc_bus_rvalid = 1'b0;
      dc.i_dc_bus_err    = 1'b0;
      dc.i_dc_bus_rdata  = $urandom;
      if (!done) begin
        if (granted && !wen && !rv_given) begin
          rd_wait++;
          if (rd_wait > r) begin
            dc.i_dc_bus_rvalid = 1'b1;
            dc.i_dc_bus_rdata  = rword;
            dc.i_dc_bus_err    = err;
            rv_given = 1;
          end
        end else if (dc.o_dc_bus_req && req_n > g) begin
          dc.i_dc_bus_gnt = 1'b1;
          dc.i_dc_bus_err = wen & err;
          granted = 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    drive_idle();
    chk({name, ":done"},      32'(done),     32'd1);
    chk({name, ":stall"},     stall_n,       exp_stall);
    chk({name, ":fault"},     fault_n,       exp_fault);
    chk({name, ":rvalid"},    rv_n,          exp_rv);
    chk({name, ":req_cyc"},   req_n,         exp_req);
    chk({name, ":bus_fld"},   bad_bus,       0);
    chk({name, ":bus_idle"},  idle_bus,      0);
    chk({name, ":rdata"},     dc.o_dc_rdata, model_rdata);
  endtask

  initial begin
    int g, r;
    logic wen, err;
    logic [2:0] f3;
    logic [31:0] addr;

    drive_idle();
    #1;
    chk("rst:stall",  32'(dc.o_dc_stall),       0);
    chk("rst:fault",  32'(dc.o_dc_fault),       0);
    chk("rst:rdata",  dc.o_dc_rdata,            0);
    chk("rst:rvalid", 32'(dc.o_dc_rdata_valid), 0);
    chk("rst:busreq", 32'(dc.o_dc_bus_req),     0);
    chk("rst:be",     32'(dc.o_dc_bus_be),      0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_access("sb",    1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 0, 1'b0, 32'h0);
    do_access("lb",    1'b0, 3'b000, 32'h0000_0202, 32'h0, 0, 0, 1'b0, 32'h80FF_1234);
    do_access("lbu",   1'b0, 3'b100, 32'h0000_0202, 32'h0, 0, 0, 1'b0, 32'h80FF_1234);
    do_access("lh",    1'b0, 3'b001, 32'h0000_0202, 32'h0, 0, 0, 1'b0, 32'h80FF_1234);
    do_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 1'b0, 32'h0);
    do_access("sw_mis", 1'b1, 3'b010, 32'h0000_0101, 32'h1234_5678, 0, 0, 1'b0, 32'h0);
    do_access("lw_slow", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 4, 1, 1'b0, 32'hDEAD_BEEF);
    do_access("sh",    1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 2, 0, 1'b0, 32'h0);
    do_access("tmo",   1'b0, 3'b010, 32'h0000_0800, 32'h0, 100, 0, 1'b0, 32'h0);
    do_access("lw_pre", 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D);

    // reset while waiting for read data
    dc.i_dc_req_valid = 1'b1;
    dc.i_dc_req_func3 = 3'b010;
    dc.i_dc_req_addr  = 32'h0000_0300;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid:inreq", 32'(dc.o_dc_bus_req), 1);
    dc.i_dc_bus_gnt = 1'b1;
    @(posedge clk); #1;
    dc.i_dc_bus_gnt = 1'b0;
    @(negedge clk);
    chk("rst_mid:inwait", 32'(dc.o_dc_stall), 1);
    rst_n = 1'b0;
    dc.i_dc_req_valid = 1'b0;
    #1;
    model_rdata = '0;
    chk("rst_mid:stall",  32'(dc.o_dc_stall),       0);
    chk("rst_mid:busreq", 32'(dc.o_dc_bus_req),     0);
    chk("rst_mid:rdata",  dc.o_dc_rdata,            model_rdata);
    chk("rst_mid:fault",  32'(dc.o_dc_fault),       0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    dc.i_dc_bus_rvalid = 1'b1;
    dc.i_dc_bus_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("late_rv:rvalid", 32'(dc.o_dc_rdata_valid), 0);
    chk("late_rv:rdata",  dc.o_dc_rdata,            model_rdata);
    @(posedge clk); #1;
    do_access("lw_post", 1'b0, 3'b010, 32'h0000_0304, 32'h0, 0, 0, 1'b0, 32'h0BAD_CAFE);

    for (int i = 0; i < 300; i++) begin
      wen  = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      g    = int'($urandom_range(0, 6));
      r    = int'($urandom_range(0, 4));
      err  = ($urandom_range(0, 7) == 0);
      do_access("rnd", wen, f3, addr, $urandom, g, r, err, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
